exec_controller: RTL
====================

EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 The block SHALL have one clock, clk_i, and an asynchronous, active-low reset, rst_ni; all state elements SHALL be clocked on the rising edge of clk_i.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk_i  in  1  system clock
- rst_ni  in  1  async active-low reset
- cmd_valid_i  in  1  debug command present
- cmd_op_i  in  2  00 PAUSE, 01 RUN, 10 STEP, 11 RESTART
- cmd_ready_o  out  1  command accepted when valid && ready
- halt_i  in  1  ECALL retiring in WB (the control unit's is_halt, staged to WB)
- cpu_en_o  out  1  pipeline advance enable (PC and all stage registers)
- pc_reset_o  out  1  one-cycle soft reset of PC and pipeline registers
- done_valid_o  out  1  one-cycle completion pulse
- done_code_o  out  2  00 PAUSED, 01 STEPPED, 10 HALTED, 11 REJECTED
- state_o  out  3  current FSM state, for debug readout
- cycle_cnt_o  out  32  count of enabled cycles since last RESTART

Function
REQ-003 The FSM SHALL have states IDLE, RUN, STEP, HALTED.
REQ-004 cmd_ready_o SHALL be 1 in IDLE, RUN and HALTED, and 0 in STEP.
REQ-005 cpu_en_o SHALL equal ((state==RUN || state==STEP) && !halt_i); it SHALL be combinational, so the ECALL cycle never advances the pipeline.
REQ-006 IDLE transitions on an accepted command:
- RUN -> RUN
- STEP -> STEP
- RESTART -> stays IDLE, with pc_reset_o pulsed and cycle_cnt_o cleared
- PAUSE -> stays IDLE, with done PAUSED
REQ-007 RUN behaviour:
- halt_i=1 -> HALTED next cycle, with done HALTED
- otherwise, an accepted PAUSE -> IDLE next cycle, with done PAUSED
- an accepted RUN is a no-op with no done pulse
- an accepted STEP or RESTART -> done REJECTED, and the FSM stays in RUN
REQ-008 STEP SHALL last exactly one cycle:
- halt_i=0 -> IDLE, with done STEPPED
- halt_i=1 -> HALTED, with done HALTED
REQ-009 HALTED behaviour:
- accepted RESTART -> IDLE, with pc_reset_o pulsed and cycle_cnt_o cleared
- any other accepted command -> done REJECTED, and the FSM stays in HALTED
REQ-010 When halt_i and an accepted command occur in the same RUN cycle, halt SHALL win: the command is consumed, and only done HALTED is emitted.
REQ-011 done_valid_o and done_code_o SHALL be registered, asserting in the cycle after the triggering event, for exactly one cycle.
REQ-012 pc_reset_o SHALL be registered, asserting in the cycle after RESTART acceptance, for exactly one cycle; cpu_en_o SHALL be 0 during that cycle.
REQ-013 cycle_cnt_o SHALL increment by 1 on every cycle with cpu_en_o=1, SHALL saturate at 32'hFFFF_FFFF, and SHALL clear on RESTART (the clear takes priority).
REQ-014 halt_i SHALL be ignored in IDLE and HALTED.
REQ-015 cmd_op_i SHALL be ignored when cmd_valid_i=0.

Reset
REQ-016 On rst_ni=0, the block SHALL immediately take state IDLE, with cpu_en_o=0, pc_reset_o=0, done_valid_o=0, done_code_o=00 and cycle_cnt_o=0; cmd_ready_o SHALL then be 1.
REQ-017 Reset asserted mid-RUN or mid-STEP SHALL abort without emitting a done pulse.
REQ-018 Reset release SHALL take effect on the next rising edge of clk_i, leaving the FSM in IDLE.

Structure
REQ-019 The state enum, command enum and done-code enum SHALL live in a shared package, exec_ctrl_pkg, for reuse by the debug unit.
REQ-020 The saturating cycle counter SHALL be a sub-module, sat_counter, parameterised by width, with enable, clear and count ports.
REQ-021 The FSM and output logic SHALL reside in exec_controller.

Verification
REQ-022 Reset-then-idle: reset, then 5 idle cycles -> cpu_en_o=0, cycle_cnt_o=0, state_o=IDLE, no done pulse.
REQ-023 Run-and-pause: RUN, wait 10 cycles, then PAUSE -> cycle_cnt_o=11; the next cycle shows done_valid_o=1 with code 00, and cpu_en_o=0.
REQ-024 Step-twice: STEP twice -> cpu_en_o is high for exactly 2 cycles in total, two STEPPED pulses are emitted, cycle_cnt_o=2, and cmd_ready_o=0 during each STEP cycle.
REQ-025 Halt race: in RUN, halt_i=1 together with an accepted PAUSE -> cpu_en_o=0 that cycle, then code 10, state HALTED; a subsequent RUN yields code 11.
REQ-026 Restart after halt: RESTART from HALTED -> pc_reset_o high for exactly one cycle, cycle_cnt_o=0, state IDLE; a following RUN counts up from 0.
REQ-027 Saturation and async reset: force the counter to FFFF_FFFE and run 3 cycles -> the counter holds FFFF_FFFF; then rst_ni low mid-cycle -> all outputs take reset values before the next edge, with no done pulse.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution controller and the debug unit that drives it.
// Keeps the state, command and completion-code encodings in one place.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_PAUSE   = 2'b00,
    CMD_RUN     = 2'b01,
    CMD_STEP    = 2'b10,
    CMD_RESTART = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    DONE_PAUSED   = 2'b00,
    DONE_STEPPED  = 2'b01,
    DONE_HALTED   = 2'b10,
    DONE_REJECTED = 2'b11
  } done_e;

  localparam int unsigned CYCLE_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A clear always wins over an enable in the same cycle.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value;

  // Counter register: clear, saturating increment, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= {WIDTH{1'b0}};
    end else if (clear) begin
      value <= {WIDTH{1'b0}};
    end else if (enable && (value != MAX_VAL)) begin
      value <= value + ONE_VAL;
    end else begin
      value <= value;
    end
  end

  assign count = value;

endmodule

// File: rtl/exec_controller.sv
// Debug execution controller: gates the pipeline enable from RUN/STEP/PAUSE/
// RESTART commands and the retiring ECALL, and reports command completion.
module exec_controller
  import exec_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  output logic        cmd_ready_o,
  input  logic        halt_i,
  output logic        cpu_en_o,
  output logic        pc_reset_o,
  output logic        done_valid_o,
  output logic [1:0]  done_code_o,
  output logic [2:0]  state_o,
  output logic [31:0] cycle_cnt_o
);

  state_e state;
  state_e state_next;
  logic   cmd_accept;
  logic   restart;
  logic   done_set;
  done_e  done_code_next;
  logic   done_valid;
  done_e  done_code;
  logic   pc_reset;

  assign cmd_ready_o = (state != ST_STEP);
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  // Combinational so the ECALL cycle itself never advances the pipeline.
  assign cpu_en_o    = ((state == ST_RUN) || (state == ST_STEP)) && !halt_i;

  // Next-state and completion decode.
  always_comb begin
    state_next     = state;
    restart        = 1'b0;
    done_set       = 1'b0;
    done_code_next = DONE_PAUSED;
    case (state)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (cmd_e'(cmd_op_i))
            CMD_RUN:     state_next = ST_RUN;
            CMD_STEP:    state_next = ST_STEP;
            CMD_RESTART: restart    = 1'b1;
            CMD_PAUSE:   done_set   = 1'b1;
            default:     state_next = ST_IDLE;
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A retiring ECALL swallows any command offered in the same cycle.
        if (halt_i) begin
          state_next     = ST_HALTED;
          done_set       = 1'b1;
          done_code_next = DONE_HALTED;
        end else if (cmd_accept) begin
          case (cmd_e'(cmd_op_i))
            CMD_PAUSE: begin
              state_next = ST_IDLE;
              done_set   = 1'b1;
            end
            CMD_RUN: state_next = ST_RUN;
            default: begin
              done_set       = 1'b1;
              done_code_next = DONE_REJECTED;
            end
          endcase
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_STEP: begin
        done_set = 1'b1;
        if (halt_i) begin
          state_next     = ST_HALTED;
          done_code_next = DONE_HALTED;
        end else begin
          state_next     = ST_IDLE;
          done_code_next = DONE_STEPPED;
        end
      end
      ST_HALTED: begin
        if (cmd_accept) begin
          if (cmd_e'(cmd_op_i) == CMD_RESTART) begin
            state_next = ST_IDLE;
            restart    = 1'b1;
          end else begin
            done_set       = 1'b1;
            done_code_next = DONE_REJECTED;
          end
        end else begin
          state_next = ST_HALTED;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and registered pulse outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      done_valid <= 1'b0;
      done_code  <= DONE_PAUSED;
      pc_reset   <= 1'b0;
    end else begin
      state      <= state_next;
      done_valid <= done_set;
      done_code  <= done_set ? done_code_next : DONE_PAUSED;
      pc_reset   <= restart;
    end
  end

  sat_counter #(
    .WIDTH(CYCLE_CNT_W)
  ) u_cycle_cnt (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .enable (cpu_en_o),
    .clear  (restart),
    .count  (cycle_cnt_o)
  );

  assign state_o      = state;
  assign done_valid_o = done_valid;
  assign done_code_o  = done_code;
  assign pc_reset_o   = pc_reset;

endmodule
